ins_seq: RTL and testbench

INS_SEQ -- requirements
Module: ins_seq

---
 rtl/uproc_pkg.sv | 39 +++
 rtl/defines.sv | 12 +
 rtl/ins_dec.sv | 50 +++++
 rtl/ins_seq.sv | 181 ++++++++++++++++++
 tb/tb_ins_seq.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/uproc_pkg.sv
// Opcode map, ALU source selects and sequencer state encoding.
package uproc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOT  = 4'h5,
        OP_LD   = 4'h6,
        OP_NOP7 = 4'h7,
        OP_ST   = 4'h8,
        OP_STR  = 4'h9,
        OP_JMP  = 4'hA,
        OP_JC   = 4'hB,
        OP_JZ   = 4'hC,
        OP_NOPD = 4'hD,
        OP_NOPE = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    localparam logic [1:0] SRC_REG = 2'b00;
    localparam logic [1:0] SRC_IMM = 2'b01;
    localparam logic [1:0] SRC_MEM = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEMWAIT,
        S_EXEC,
        S_HALT
    } state_e;

    function automatic logic is_alu_op(input opcode_e op);
        return op <= OP_LD;
    endfunction

endpackage

// File: rtl/defines.sv
// ALU operation codes shared by the datapath and the instruction sequencer.
`ifndef UPROC_DEFINES_SV
`define UPROC_DEFINES_SV
`define ALU_ADD 3'd0
`define ALU_SUB 3'd1
`define ALU_AND 3'd2
`define ALU_OR  3'd3
`define ALU_XOR 3'd4
`define ALU_NOT 3'd5
`define ALU_LD  3'd6
`define ALU_NOP 3'd7
`endif

// File: rtl/ins_dec.sv
// Combinational instruction decoder: splits IR into fields and class flags.
// Zero latency; no flow control.
`include "defines.sv"

module ins_dec
    import uproc_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  alu_code,
    output logic [1:0]  src_sel,
    output logic [7:0]  operand,
    output logic        ci_en,
    output logic        wr_carry,
    output logic        is_alu,
    output logic        is_mem_alu,
    output logic        is_st,
    output logic        is_str,
    output logic        is_jmp,
    output logic        is_jc,
    output logic        is_jz,
    output logic        is_halt
);

    opcode_e op;
    logic    unused_ir8;

    assign op         = opcode_e'(ir[15:12]);
    assign unused_ir8 = ir[8];

    always_comb begin
        is_alu   = is_alu_op(op);
        alu_code = is_alu ? ir[14:12] : `ALU_NOP;
        wr_carry = is_alu && (alu_code == `ALU_ADD || alu_code == `ALU_SUB);
        // The reserved source 11 falls back to the register file.
        src_sel  = SRC_REG;
        if (is_alu && ir[11:10] != 2'b11) begin
            src_sel = ir[11:10];
        end
        is_mem_alu = is_alu && (src_sel == SRC_MEM);
        ci_en      = ir[9] && wr_carry;
        operand    = ir[7:0];
        is_st      = (op == OP_ST);
        is_str     = (op == OP_STR);
        is_jmp     = (op == OP_JMP);
        is_jc      = (op == OP_JC);
        is_jz      = (op == OP_JZ);
        is_halt    = (op == OP_HALT);
    end

endmodule

// File: rtl/ins_seq.sv
// Multi-cycle instruction sequencer: fetch/decode/memwait/exec FSM, PC and ALU control registers.
// 3 cycles per instruction, stalls in MEMWAIT until MemAck; HALT is left only through Rst.
`include "defines.sv"

module ins_seq
    import uproc_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [15:0]     InsIn,
    output logic [PC_W-1:0] PC,
    input  logic            CarryFlag,
    input  logic            AccuZero,
    input  logic            MemAck,
    output logic [2:0]      ALUCode,
    output logic            Ci,
    output logic [1:0]      SrcSel,
    output logic [7:0]      Operand,
    output logic            AccuWE,
    output logic            CarryWE,
    output logic            RegWE,
    output logic            MemReq,
    output logic            MemWr,
    output logic            Halted
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic [2:0]      alu_code_q, alu_code_d;
    logic [1:0]      src_sel_q, src_sel_d;
    logic [7:0]      operand_q, operand_d;
    logic            ci_q, ci_d;
    logic            accu_we_q, accu_we_d;
    logic            carry_we_q, carry_we_d;
    logic            reg_we_q, reg_we_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_wr_q, mem_wr_d;
    logic            halted_q, halted_d;

    logic [2:0] dec_alu_code;
    logic [1:0] dec_src_sel;
    logic [7:0] dec_operand;
    logic       dec_ci_en, dec_wr_carry, dec_is_alu, dec_is_mem_alu;
    logic       dec_is_st, dec_is_str, dec_is_jmp, dec_is_jc, dec_is_jz, dec_is_halt;

    ins_dec u_dec (
        .ir         (ir_q),
        .alu_code   (dec_alu_code),
        .src_sel    (dec_src_sel),
        .operand    (dec_operand),
        .ci_en      (dec_ci_en),
        .wr_carry   (dec_wr_carry),
        .is_alu     (dec_is_alu),
        .is_mem_alu (dec_is_mem_alu),
        .is_st      (dec_is_st),
        .is_str     (dec_is_str),
        .is_jmp     (dec_is_jmp),
        .is_jc      (dec_is_jc),
        .is_jz      (dec_is_jz),
        .is_halt    (dec_is_halt)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        alu_code_d = alu_code_q;
        src_sel_d  = src_sel_q;
        operand_d  = operand_q;
        ci_d       = ci_q;
        accu_we_d  = 1'b0;
        carry_we_d = 1'b0;
        reg_we_d   = 1'b0;
        mem_req_d  = mem_req_q;
        mem_wr_d   = mem_wr_q;
        halted_d   = halted_q;

        case (state_q)
            S_FETCH: begin
                ir_d    = InsIn;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_code_d = dec_alu_code;
                src_sel_d  = dec_src_sel;
                operand_d  = dec_operand;
                ci_d       = dec_ci_en && CarryFlag;
                if (dec_is_mem_alu || dec_is_st) begin
                    state_d   = S_MEMWAIT;
                    mem_req_d = 1'b1;
                    mem_wr_d  = dec_is_st;
                end else if (dec_is_halt) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    // Strobes are registered so they are live exactly during EXEC.
                    state_d    = S_EXEC;
                    accu_we_d  = dec_is_alu;
                    carry_we_d = dec_wr_carry;
                    reg_we_d   = dec_is_str;
                end
            end
            S_MEMWAIT: begin
                if (MemAck) begin
                    mem_req_d = 1'b0;
                    mem_wr_d  = 1'b0;
                    if (dec_is_st) begin
                        state_d = S_FETCH;
                        pc_d    = pc_q + PC_W'(1);
                    end else begin
                        state_d    = S_EXEC;
                        accu_we_d  = 1'b1;
                        carry_we_d = dec_wr_carry;
                    end
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (dec_is_jmp || (dec_is_jc && CarryFlag) || (dec_is_jz && AccuZero)) begin
                    pc_d = PC_W'(operand_q);
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            alu_code_q <= `ALU_NOP;
            src_sel_q  <= SRC_REG;
            operand_q  <= '0;
            ci_q       <= 1'b0;
            accu_we_q  <= 1'b0;
            carry_we_q <= 1'b0;
            reg_we_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_wr_q   <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            alu_code_q <= alu_code_d;
            src_sel_q  <= src_sel_d;
            operand_q  <= operand_d;
            ci_q       <= ci_d;
            accu_we_q  <= accu_we_d;
            carry_we_q <= carry_we_d;
            reg_we_q   <= reg_we_d;
            mem_req_q  <= mem_req_d;
            mem_wr_q   <= mem_wr_d;
            halted_q   <= halted_d;
        end
    end

    assign PC      = pc_q;
    assign ALUCode = alu_code_q;
    assign Ci      = ci_q;
    assign SrcSel  = src_sel_q;
    assign Operand = operand_q;
    assign AccuWE  = accu_we_q;
    assign CarryWE = carry_we_q;
    assign RegWE   = reg_we_q;
    assign MemReq  = mem_req_q;
    assign MemWr   = mem_wr_q;
    assign Halted  = halted_q;

endmodule

// File: tb/tb_ins_seq.sv
// Bench for ins_seq: directed programs plus random instructions against an instruction-level model.
module tb_ins_seq;

    logic        Clk;
    logic        Rst;
    logic [15:0] InsIn;
    logic [7:0]  PC;
    logic        CarryFlag, AccuZero, MemAck;
    logic [2:0]  ALUCode;
    logic        Ci;
    logic [1:0]  SrcSel;
    logic [7:0]  Operand;
    logic        AccuWE, CarryWE, RegWE, MemReq, MemWr, Halted;

    logic [15:0] prog [256];
    logic [7:0]  pc_m;
    int          vectors;
    int          miscompares;

    ins_seq #(.PC_W(8)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .InsIn     (InsIn),
        .PC        (PC),
        .CarryFlag (CarryFlag),
        .AccuZero  (AccuZero),
        .MemAck    (MemAck),
        .ALUCode   (ALUCode),
        .Ci        (Ci),
        .SrcSel    (SrcSel),
        .Operand   (Operand),
        .AccuWE    (AccuWE),
        .CarryWE   (CarryWE),
        .RegWE     (RegWE),
        .MemReq    (MemReq),
        .MemWr     (MemWr),
        .Halted    (Halted)
    );

    assign InsIn = prog[PC];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] src,
                                        input logic usec, input logic [7:0] opnd);
        logic b8;
        b8 = 1'($urandom_range(0, 1));
        return {op, src, usec, b8, opnd};
    endfunction

    task automatic do_reset();
        Rst    = 1'b1;
        MemAck = 1'b1;
        #1;
        chk("rst_pc", PC, 16'h0);
        chk("rst_alucode", ALUCode, 16'h7);
        chk("rst_srcsel", SrcSel, 16'h0);
        chk("rst_operand", Operand, 16'h0);
        chk("rst_ci", Ci, 16'h0);
        chk("rst_accuwe", AccuWE, 16'h0);
        chk("rst_carrywe", CarryWE, 16'h0);
        chk("rst_regwe", RegWE, 16'h0);
        chk("rst_memreq", MemReq, 16'h0);
        chk("rst_memwr", MemWr, 16'h0);
        chk("rst_halted", Halted, 16'h0);
        tick();
        chk("rst_hold_pc", PC, 16'h0);
        chk("rst_hold_memreq", MemReq, 16'h0);
        chk("rst_hold_accuwe", AccuWE, 16'h0);
        Rst    = 1'b0;
        MemAck = 1'b0;
        pc_m   = 8'h00;
    endtask

    // Executes one instruction at the model PC, checking every cycle it spans.
    task automatic step(input logic [15:0] ins, input int n_ack, input logic c, input logic z);
        logic [3:0] op;
        logic [1:0] src;
        logic [7:0] opnd, nxt;
        bit         alu, addsub, mem, st, halt, taken, exec, mreq;
        int         nmw, lat;
        prog[pc_m] = ins;
        op     = ins[15:12];
        src    = ins[11:10];
        opnd   = ins[7:0];
        alu    = (op <= 4'd6);
        addsub = (op <= 4'd1);
        if (alu && src == 2'b11) src = 2'b00;
        st     = (op == 4'd8);
        mem    = (alu && src == 2'b10) || st;
        halt   = (op == 4'hF);
        taken  = (op == 4'hA) || (op == 4'hB && c) || (op == 4'hC && z);
        nmw    = mem ? n_ack : 0;
        lat    = halt ? 2 : (st ? 2 + nmw : 3 + nmw);
        nxt    = taken ? opnd : pc_m + 8'd1;
        CarryFlag = c;
        AccuZero  = z;
        for (int cy = 1; cy <= lat; cy++) begin
            mreq   = (cy >= 3 && cy <= 2 + nmw);
            MemAck = mreq ? (cy == 2 + nmw) : 1'($urandom_range(0, 1));
            exec   = !st && !halt && (cy == lat);
            chk("pc", PC, pc_m);
            chk("memreq", MemReq, mreq);
            if (mreq) begin
                chk("memwr", MemWr, st);
                chk("mem_addr", Operand, opnd);
            end
            chk("accuwe", AccuWE, exec && alu);
            chk("carrywe", CarryWE, exec && addsub);
            chk("regwe", RegWE, exec && op == 4'd9);
            if (exec && alu) begin
                chk("alucode", ALUCode, op[2:0]);
                chk("ci", Ci, ins[9] && addsub && c);
                chk("srcsel", SrcSel, src);
                chk("operand", Operand, opnd);
            end
            chk("halted", Halted, 16'h0);
            tick();
        end
        MemAck = 1'b0;
        if (halt) begin
            for (int cy = 0; cy < 4; cy++) begin
                MemAck = 1'($urandom_range(0, 1));
                chk("halt_flag", Halted, 16'h1);
                chk("halt_pc", PC, pc_m);
                chk("halt_accuwe", AccuWE, 16'h0);
                chk("halt_carrywe", CarryWE, 16'h0);
                chk("halt_regwe", RegWE, 16'h0);
                chk("halt_memreq", MemReq, 16'h0);
                tick();
            end
            MemAck = 1'b0;
        end else begin
            pc_m = nxt;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Rst         = 1'b1;
        MemAck      = 1'b0;
        CarryFlag   = 1'b0;
        AccuZero    = 1'b0;
        pc_m        = 8'h00;
        for (int i = 0; i < 256; i++) prog[i] = 16'h7000;

        do_reset();
        // LD #5; ADD #3; HALT
        step(enc(4'h6, 2'b01, 1'b0, 8'd5), 1, 1'b0, 1'b0);
        step(enc(4'h0, 2'b01, 1'b0, 8'd3), 1, 1'b0, 1'b0);
        step(enc(4'hF, 2'b00, 1'b0, 8'd0), 1, 1'b0, 1'b0);

        do_reset();
        step(enc(4'h0, 2'b01, 1'b1, 8'd1), 1, 1'b1, 1'b0);
        step(enc(4'h0, 2'b01, 1'b0, 8'd1), 1, 1'b1, 1'b0);
        step(enc(4'h1, 2'b01, 1'b1, 8'd7), 1, 1'b1, 1'b1);
        step(enc(4'h2, 2'b01, 1'b1, 8'd7), 1, 1'b1, 1'b0);

        // Data-memory loads and stores with slow and immediate acknowledge
        step(enc(4'h6, 2'b10, 1'b0, 8'h20), 4, 1'b0, 1'b0);
        step(enc(4'h6, 2'b10, 1'b0, 8'h20), 1, 1'b0, 1'b0);
        step(enc(4'h8, 2'b00, 1'b0, 8'h21), 3, 1'b0, 1'b0);
        step(enc(4'h8, 2'b00, 1'b0, 8'h22), 1, 1'b0, 1'b0);
        step(enc(4'h4, 2'b11, 1'b0, 8'h05), 1, 1'b0, 1'b0);
        step(enc(4'h9, 2'b00, 1'b0, 8'h05), 1, 1'b0, 1'b0);

        do_reset();
        step(enc(4'hB, 2'b00, 1'b0, 8'h10), 1, 1'b0, 1'b0);
        step(enc(4'hB, 2'b00, 1'b0, 8'h10), 1, 1'b1, 1'b0);
        step(enc(4'hC, 2'b00, 1'b0, 8'h40), 1, 1'b0, 1'b1);
        step(enc(4'hC, 2'b00, 1'b0, 8'h80), 1, 1'b0, 1'b0);
        step(enc(4'hA, 2'b00, 1'b0, 8'hFF), 1, 1'b0, 1'b0);
        step(enc(4'hC, 2'b00, 1'b0, 8'h30), 1, 1'b0, 1'b0);
        step(enc(4'hA, 2'b00, 1'b0, 8'hFF), 1, 1'b0, 1'b0);
        step(enc(4'h7, 2'b00, 1'b0, 8'h30), 1, 1'b1, 1'b1);

        // Reserved opcodes behave as NOPs
        step(enc(4'h7, 2'b01, 1'b1, 8'h55), 1, 1'b1, 1'b1);
        step(enc(4'hD, 2'b10, 1'b1, 8'h66), 1, 1'b1, 1'b1);
        step(enc(4'hE, 2'b11, 1'b1, 8'h77), 1, 1'b0, 1'b1);

        // Reset in the middle of a memory wait
        prog[pc_m] = enc(4'h6, 2'b10, 1'b0, 8'h33);
        MemAck = 1'b0;
        tick();
        tick();
        chk("memwait_req_before_rst", MemReq, 16'h1);
        do_reset();
        step(enc(4'h6, 2'b10, 1'b0, 8'h33), 2, 1'b0, 1'b0);

        repeat (80) begin
            step(enc(4'($urandom_range(0, 14)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 8'($urandom_range(0, 255))),
                 $urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        step(enc(4'hF, 2'b00, 1'b0, 8'h00), 1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
